// File: rtl/ula_fp_seq.sv
// ula_fp_seq: issue/sequencing controller for the FP unit; holds operands, times core latency, captures result and sticky flags.
module ula_fp_seq #(
  parameter int WIDTH    = 32,
  parameter int CNT_W    = 5,
  parameter int LAT_ADD  = 7,
  parameter int LAT_MUL  = 5,
  parameter int LAT_DIV  = 6,
  parameter int LAT_SQRT = 16,
  parameter int LAT_CMP  = 1,
  parameter int LAT_CVT  = 6
) (
  input  logic             iclock,
  input  logic             ireset,
  input  logic             istart,
  input  logic [3:0]       icontrol,
  input  logic [WIDTH-1:0] idataa,
  input  logic [WIDTH-1:0] idatab,
  input  logic             iclear_sticky,
  output logic [WIDTH-1:0] ocore_dataa,
  output logic [WIDTH-1:0] ocore_datab,
  output logic [3:0]       ocore_op,
  output logic             ocore_addsub,
  input  logic [WIDTH-1:0] icore_result,
  input  logic             icore_nan,
  input  logic             icore_zero,
  input  logic             icore_overflow,
  input  logic             icore_underflow,
  input  logic             icore_cmp,
  output logic             obusy,
  output logic             odone,
  output logic [WIDTH-1:0] oresult,
  output logic             onan,
  output logic             ozero,
  output logic             ooverflow,
  output logic             ounderflow,
  output logic             oCompResult,
  output logic [2:0]       osticky
);
  localparam logic [3:0] ADDS = 4'd0, SUBS = 4'd1, MULS = 4'd2, DIVS = 4'd3, SQRT = 4'd4, ABS = 4'd5,
                         NEG = 4'd6, CEQ = 4'd7, CLE = 4'd9, CVTSW = 4'd10, CVTWS = 4'd11;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, lat;
  logic             accept, cap, arith, is_cmp, cvtws, core_res;
  logic [WIDTH-1:0] res_n;
  logic             nan_n, zero_n, ovf_n, unf_n, cmp_n;
  assign obusy  = state == WAIT;
  assign accept = state == IDLE && istart;
  assign cap    = state == WAIT && cnt == CNT_W'(1);
  always_ff @(posedge iclock or posedge ireset)
    if (ireset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = accept ? WAIT : cap ? IDLE : state;
    lat = (icontrol == ADDS || icontrol == SUBS) ? CNT_W'(LAT_ADD) :
          (icontrol == MULS) ? CNT_W'(LAT_MUL) :
          (icontrol == DIVS) ? CNT_W'(LAT_DIV) :
          (icontrol == SQRT) ? CNT_W'(LAT_SQRT) :
          (icontrol >= CEQ && icontrol <= CLE) ? CNT_W'(LAT_CMP) :
          (icontrol == CVTSW || icontrol == CVTWS) ? CNT_W'(LAT_CVT) : CNT_W'(1);
  end
  // Result/flag selection works off the latched opcode, which also steers the external core mux
  always_comb begin
    arith    = ocore_op <= SQRT;
    is_cmp   = ocore_op >= CEQ && ocore_op <= CLE;
    cvtws    = ocore_op == CVTWS;
    core_res = arith || ocore_op == CVTSW || cvtws;
    res_n    = core_res ? icore_result :
               (ocore_op == ABS) ? {1'b0, ocore_dataa[WIDTH-2:0]} :
               (ocore_op == NEG) ? {~ocore_dataa[WIDTH-1], ocore_dataa[WIDTH-2:0]} : '0;
    nan_n    = (arith || cvtws) && icore_nan;
    ovf_n    = (arith || cvtws) && icore_overflow;
    unf_n    = (arith || cvtws) && icore_underflow;
    zero_n   = arith ? icore_zero : cvtws && icore_result == '0;
    cmp_n    = is_cmp && icore_cmp;
  end
  always_ff @(posedge iclock or posedge ireset)
    if (ireset) begin
      ocore_dataa  <= '0;
      ocore_datab  <= '0;
      ocore_op     <= '0;
      ocore_addsub <= 1'b0;
      cnt          <= '0;
      odone        <= 1'b0;
      oresult      <= '0;
      {onan, ozero, ooverflow, ounderflow, oCompResult} <= '0;
      osticky      <= '0;
    end else begin
      odone <= cap;
      if (accept) begin
        ocore_dataa  <= idataa;
        ocore_datab  <= idatab;
        ocore_op     <= icontrol;
        ocore_addsub <= icontrol == ADDS;
        cnt          <= lat;
      end else if (obusy) cnt <= cnt - CNT_W'(1);
      if (cap) begin
        oresult <= res_n;
        {onan, ozero, ooverflow, ounderflow, oCompResult} <= {nan_n, zero_n, ovf_n, unf_n, cmp_n};
      end
      // A clear on the capture edge keeps exactly the freshly captured flags
      osticky <= (iclear_sticky ? 3'b000 : osticky) | (cap ? {nan_n, ovf_n, unf_n} : 3'b000);
    end
endmodule

// File: tb/tb_ula_fp_seq.sv
// tb_ula_fp_seq: randomized and directed checks of ula_fp_seq against a behavioural opcode model.
module tb_ula_fp_seq;
  logic        iclock = 0, ireset = 1, istart = 0, iclear_sticky = 0;
  logic [3:0]  icontrol = 0;
  logic [31:0] idataa = 0, idatab = 0, icore_result = 0;
  logic        icore_nan = 0, icore_zero = 0, icore_overflow = 0, icore_underflow = 0, icore_cmp = 0;
  logic [31:0] ocore_dataa, ocore_datab, oresult;
  logic [3:0]  ocore_op;
  logic        ocore_addsub, obusy, odone, onan, ozero, ooverflow, ounderflow, oCompResult;
  logic [2:0]  osticky;
  logic [2:0]  sticky_m = 0;
  int          errs = 0, checks = 0;

  ula_fp_seq #(.WIDTH(32), .CNT_W(5), .LAT_ADD(7), .LAT_MUL(5), .LAT_DIV(6), .LAT_SQRT(16),
               .LAT_CMP(1), .LAT_CVT(6)) dut (
    .iclock(iclock), .ireset(ireset), .istart(istart), .icontrol(icontrol), .idataa(idataa),
    .idatab(idatab), .iclear_sticky(iclear_sticky), .ocore_dataa(ocore_dataa),
    .ocore_datab(ocore_datab), .ocore_op(ocore_op), .ocore_addsub(ocore_addsub),
    .icore_result(icore_result), .icore_nan(icore_nan), .icore_zero(icore_zero),
    .icore_overflow(icore_overflow), .icore_underflow(icore_underflow), .icore_cmp(icore_cmp),
    .obusy(obusy), .odone(odone), .oresult(oresult), .onan(onan), .ozero(ozero),
    .ooverflow(ooverflow), .ounderflow(ounderflow), .oCompResult(oCompResult), .osticky(osticky));

  always #5 iclock = ~iclock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [3:0] op);
    case (op)
      0, 1: return 7;
      2: return 5;
      3: return 6;
      4: return 16;
      7, 8, 9: return 1;
      10, 11: return 6;
      default: return 1;
    endcase
  endfunction

  // fl = {nan, zero, overflow, underflow} presented by the core model for the whole operation
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [3:0] fl, input logic cmp,
                        input logic clr, input int poke);
    int busy = 0;
    bit done = 0;
    logic [31:0] er;
    logic [3:0]  ef;
    logic        ec;
    er = 0; ef = 0; ec = 0;
    case (op)
      0, 1, 2, 3, 4: begin er = res; ef = fl; end
      5: er = a & 32'h7FFF_FFFF;
      6: er = a ^ 32'h8000_0000;
      7, 8, 9: ec = cmp;
      10: er = res;
      11: begin er = res; ef = {fl[3], res == 0, fl[1], fl[0]}; end
      default: ;
    endcase
    sticky_m = (clr ? 3'b000 : sticky_m) | {ef[3], ef[1], ef[0]};
    @(negedge iclock);
    icontrol = op; idataa = a; idatab = b; icore_result = res; icore_cmp = cmp;
    {icore_nan, icore_zero, icore_overflow, icore_underflow} = fl;
    iclear_sticky = clr; istart = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge iclock);
      istart = 0;
      if (odone) done = 1;
      else if (obusy) begin
        busy++;
        if (busy == poke) begin
          istart = 1; idataa = $urandom; idatab = $urandom; icontrol = 4'($urandom);
        end
      end
    end
    iclear_sticky = 0;
    chk($sformatf("done op%0d", op), 32'(done), 1);
    chk($sformatf("busy op%0d", op), busy, lat_of(op));
    chk($sformatf("result op%0d", op), oresult, er);
    chk($sformatf("flags op%0d", op), {onan, ozero, ooverflow, ounderflow}, ef);
    chk($sformatf("cmp op%0d", op), oCompResult, ec);
    chk($sformatf("sticky op%0d", op), osticky, sticky_m);
    chk($sformatf("core_a op%0d", op), ocore_dataa, a);
    chk($sformatf("core_b op%0d", op), ocore_datab, b);
    chk($sformatf("core_op op%0d", op), ocore_op, op);
    chk($sformatf("addsub op%0d", op), ocore_addsub, op == 0);
    @(negedge iclock);
    chk($sformatf("pulse op%0d", op), odone, 0);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge iclock);
    chk("rst busy", obusy, 0);
    chk("rst result", oresult, 0);
    chk("rst addsub", ocore_addsub, 0);
    chk("rst sticky", osticky, 0);
    ireset = 0;
    run_op(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 0, 0, -1);
    run_op(6, 32'h3F80_0000, 0, 32'h1234_5678, 4'b1111, 1, 0, -1);
    run_op(5, 32'hC049_0FDB, 0, 32'h1234_5678, 4'b1111, 1, 0, -1);
    run_op(3, 32'h1, 32'h2, 32'h7F80_0000, 4'b0010, 0, 0, -1);
    run_op(4, 32'h3, 32'h4, 32'h7FC0_0000, 4'b1000, 0, 0, -1);
    run_op(3, 32'h5, 32'h6, 32'h7F80_0000, 4'b0010, 0, 0, -1);
    run_op(4, 32'h7, 32'h8, 32'h7FC0_0000, 4'b1000, 0, 1, -1);
    run_op(8, 32'h9, 32'hA, 32'hDEAD_BEEF, 4'b1111, 1, 0, -1);
    run_op(11, 32'hB, 32'hC, 32'h0, 4'b0000, 0, 0, -1);
    run_op(4, 32'h4100_0000, 32'h0, 32'h4035_04F3, 4'b0000, 0, 0, 3);
    for (int n = 0; n < 40; n++) begin
      logic [31:0] r;
      r = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      run_op(4'($urandom), $urandom, $urandom, r, 4'($urandom), 1'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 1) ? 2 : -1);
    end
    // abort a MULS three cycles after accept
    @(negedge iclock);
    icontrol = 2; idataa = 32'h4040_0000; idatab = 32'h4000_0000; icore_result = 32'h40C0_0000;
    istart = 1;
    @(negedge iclock);
    istart = 0;
    repeat (2) @(negedge iclock);
    #2 ireset = 1;
    #1;
    chk("abort busy", obusy, 0);
    chk("abort result", oresult, 0);
    chk("abort core_a", ocore_dataa, 0);
    chk("abort sticky", osticky, 0);
    sticky_m = 0;
    repeat (2) @(negedge iclock);
    ireset = 0;
    seen = 0;
    repeat (8) begin
      @(negedge iclock);
      if (odone) seen = 1;
    end
    chk("abort nodone", 32'(seen), 0);
    run_op(0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0000, 0, 0, -1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
